// File: rtl/sram_like_arbiter.sv
// Two-master to one-slave sram-like arbiter: data has priority over instruction
// fetch with a streak limit, and an ID FIFO routes in-order responses back.
module sram_like_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STREAK_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata,

  output logic        proto_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } lock_e;

  lock_e           state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [SW-1:0]   streak_q, streak_d;
  logic [DEPTH-1:0] id_mem;
  logic            proto_err_q;

  logic gnt_i, gnt_d;
  logic fifo_full, fifo_empty;
  logic push, pop, head_id;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign head_id    = id_mem[rd_ptr_q];

  // Grant selection. A lock keeps the current master granted regardless of
  // priority or FIFO occupancy until the slave accepts or the master drops req.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_full) begin
            if (data_req && !(inst_req && streak_q == STREAK_LIM)) gnt_d = 1'b1;
            else if (inst_req)                                      gnt_i = 1'b1;
          end
        end
        LOCK_I:  gnt_i = inst_req;
        LOCK_D:  gnt_d = data_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_d && !addr_ok)      state_d = LOCK_D;
        else if (gnt_i && !addr_ok) state_d = LOCK_I;
      end
      LOCK_I:  if (!inst_req || addr_ok) state_d = IDLE;
      LOCK_D:  if (!data_req || addr_ok) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slave-side request forwarding.
  always_comb begin
    req   = gnt_i | gnt_d;
    wr    = 1'b0;
    size  = 2'd0;
    addr  = 32'd0;
    wdata = 32'd0;
    if (gnt_d) begin
      wr    = data_wr;
      size  = data_size;
      addr  = data_addr;
      wdata = data_wdata;
    end else if (gnt_i) begin
      wr    = inst_wr;
      size  = inst_size;
      addr  = inst_addr;
      wdata = inst_wdata;
    end
  end

  assign inst_addr_ok = gnt_i & addr_ok;
  assign data_addr_ok = gnt_d & addr_ok;
  assign push         = req & addr_ok;

  // Responses come back in issue order, so the FIFO head names the owner.
  assign pop          = data_ok & ~fifo_empty & ~reset;
  assign inst_data_ok = pop & ~head_id;
  assign data_data_ok = pop & head_id;
  assign inst_rdata   = reset ? 32'd0 : rdata;
  assign data_rdata   = reset ? 32'd0 : rdata;
  assign proto_err    = proto_err_q & ~reset;

  always_comb begin
    streak_d = streak_q;
    if (push) begin
      if (gnt_d && inst_req) streak_d = (streak_q == STREAK_LIM) ? streak_q : streak_q + 1'b1;
      else                   streak_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      streak_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
      if (data_ok && fifo_empty) proto_err_q <= 1'b1;
    end
  end

  // NOTE: ID storage has no reset; an entry is only read after it was written, tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr_q] <= gnt_d;
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized bench for sram_like_arbiter: a spec-level model predicts grants,
// and a scoreboard checks routed responses against accepted request order.
module tb_sram_like_arbiter;

  localparam int DEPTH      = 4;
  localparam int STREAK_MAX = 3;

  logic        clk, reset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic        proto_err;

  sram_like_arbiter #(.DEPTH(DEPTH), .STREAK_MAX(STREAK_MAX)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {G_NONE, G_INST, G_DATA} gnt_e;
  typedef struct packed {
    logic        id;
    logic [31:0] rdata;
  } rsp_t;

  int   checks = 0;
  int   errors = 0;

  // Reference model state: outstanding responses, streak, lock owner.
  rsp_t slave_q[$];
  rsp_t sb_q[$];
  int   streak = 0;
  gnt_e lock   = G_NONE;
  bit   perr   = 0;
  bit   inst_pend = 0;
  bit   data_pend = 0;

  function automatic gnt_e model_grant();
    if (lock == G_INST) return inst_req ? G_INST : G_NONE;
    if (lock == G_DATA) return data_req ? G_DATA : G_NONE;
    if (slave_q.size() >= DEPTH) return G_NONE;
    if (data_req && !(inst_req && streak == STREAK_MAX)) return G_DATA;
    if (inst_req) return G_INST;
    return G_NONE;
  endfunction

  // Response monitor: pops the scoreboard whenever the DUT routes a response.
  always @(negedge clk) begin
    if (!reset) begin
      if (inst_data_ok || data_data_ok) begin
        checks++;
        if (inst_data_ok && data_data_ok) begin
          errors++;
          $display("FAIL resp_both: inst_data_ok=1 data_data_ok=1, want exactly one");
        end else if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL resp_extra: got inst_ok=%0b data_ok=%0b with no outstanding request",
                   inst_data_ok, data_data_ok);
        end else begin
          rsp_t e;
          logic [31:0] got;
          e   = sb_q.pop_front();
          got = data_data_ok ? data_rdata : inst_rdata;
          if (data_data_ok !== e.id || got !== e.rdata) begin
            errors++;
            $display("FAIL resp_route: got data_side=%0b rdata=%h, want data_side=%0b rdata=%h",
                     data_data_ok, got, e.id, e.rdata);
          end
        end
      end else if (data_ok && sb_q.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL resp_missing: data_ok with %0d outstanding but no routed response", sb_q.size());
      end
    end
  end

  // One clock of stimulus, called #1 after a posedge; returns #1 after the next posedge.
  task automatic run_cycle(input int p_i, input int p_d, input int p_aok, input int p_dok,
                           input bit stray);
    gnt_e        g;
    bit          acc, pop_m, exp_req;
    logic [66:0] exp_f, got_f;
    rsp_t        e;
    if (inst_pend && $urandom_range(99) < 3) inst_pend = 0;
    else if (!inst_pend && $urandom_range(99) < p_i) begin
      inst_pend  = 1;
      inst_wr    = ($urandom_range(9) == 0);
      inst_size  = 2'($urandom_range(2));
      inst_addr  = $urandom;
      inst_wdata = $urandom;
    end
    if (data_pend && $urandom_range(99) < 3) data_pend = 0;
    else if (!data_pend && $urandom_range(99) < p_d) begin
      data_pend  = 1;
      data_wr    = 1'($urandom_range(1));
      data_size  = 2'($urandom_range(2));
      data_addr  = $urandom;
      data_wdata = $urandom;
    end
    inst_req = inst_pend;
    data_req = data_pend;
    addr_ok  = ($urandom_range(99) < p_aok);
    data_ok  = stray || (slave_q.size() > 0 && $urandom_range(99) < p_dok);
    rdata    = (slave_q.size() > 0) ? slave_q[0].rdata : $urandom;

    @(negedge clk);
    g       = model_grant();
    exp_req = (g != G_NONE);
    exp_f   = (g == G_DATA) ? {data_wr, data_size, data_addr, data_wdata}
                            : {inst_wr, inst_size, inst_addr, inst_wdata};
    got_f   = {wr, size, addr, wdata};
    checks++;
    if (req !== exp_req || inst_addr_ok !== (g == G_INST && addr_ok) ||
        data_addr_ok !== (g == G_DATA && addr_ok) || (exp_req && got_f !== exp_f)) begin
      errors++;
      $display("FAIL grant: got req=%0b iok=%0b dok=%0b fields=%h, want req=%0b iok=%0b dok=%0b fields=%h",
               req, inst_addr_ok, data_addr_ok, got_f, exp_req,
               (g == G_INST && addr_ok), (g == G_DATA && addr_ok), exp_f);
    end
    checks++;
    if (proto_err !== perr) begin
      errors++;
      $display("FAIL proto_err: got %0b want %0b", proto_err, perr);
    end
    acc   = exp_req && addr_ok;
    pop_m = data_ok && slave_q.size() > 0;

    @(posedge clk);
    if (data_ok && slave_q.size() == 0) perr = 1;
    if (pop_m) void'(slave_q.pop_front());
    if (acc) begin
      e.id    = (g == G_DATA);
      e.rdata = $urandom;
      slave_q.push_back(e);
      sb_q.push_back(e);
      if (g == G_DATA) begin
        streak    = inst_req ? ((streak < STREAK_MAX) ? streak + 1 : STREAK_MAX) : 0;
        data_pend = 0;
      end else begin
        streak    = 0;
        inst_pend = 0;
      end
    end
    lock = (exp_req && !addr_ok) ? g : G_NONE;
    #1;
  endtask

  // Holds reset with busy inputs; every output must read zero meanwhile.
  task automatic do_reset(input int ncyc);
    reset = 1; inst_pend = 0; data_pend = 0;
    inst_req = 1; data_req = 1; addr_ok = 1; data_ok = 1; rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      checks++;
      if ({req, wr, size, addr, wdata, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok,
           inst_rdata, data_rdata, proto_err} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: req=%0b addr=%h iok=%0b dok=%0b idat=%0b ddat=%0b rd=%h perr=%0b, want all 0",
                 req, addr, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, inst_rdata, proto_err);
      end
      @(posedge clk);
      #1;
    end
    slave_q.delete();
    sb_q.delete();
    streak = 0; lock = G_NONE; perr = 0;
    inst_req = 0; data_req = 0; addr_ok = 0; data_ok = 0;
    reset = 0;
  endtask

  initial begin
    reset = 1;
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 32'hBFC0_0000; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
    addr_ok = 0; data_ok = 0; rdata = 0;
    @(posedge clk);
    #1;
    do_reset(2);

    repeat (400) run_cycle(50, 50, 70, 50, 0);  // balanced traffic
    repeat (150) run_cycle(60, 60, 80, 5, 0);   // fill the ID FIFO
    repeat (100) run_cycle(10, 10, 50, 90, 0);  // drain
    repeat (200) run_cycle(95, 95, 95, 60, 0);  // contention, streak forcing
    repeat (200) run_cycle(80, 80, 20, 50, 0);  // long locks
    repeat (300) run_cycle(40, 70, 60, 40, 0);

    // Reset with responses outstanding, then a stray response.
    for (int k = 0; k < 200 && slave_q.size() < 2; k++) run_cycle(90, 90, 90, 0, 0);
    checks++;
    if (slave_q.size() < 2) begin
      errors++;
      $display("FAIL prefill: got %0d outstanding, want >= 2", slave_q.size());
    end
    do_reset(1);
    run_cycle(0, 0, 0, 0, 1);
    repeat (100) run_cycle(50, 50, 70, 50, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
